fft_frame_scheduler: RTL

Front-end sequencer for the radix-4 SDF FFT stage chain. It accepts a serial complex sample stream over a valid/ready handshake and packs it into a frame buffer of NUM_SAMPLES samples. It then drives the first stage's `input_en` and 4-lane data as one contiguous burst of NUM_SAMPLES/4 beats, followed by a mandatory flush gap so stage counters return to zero. It also counts last-stage output beats to report frame completion and protocol errors.

---
 rtl/fft_sched_pkg.sv | 13 +
 rtl/fft_frame_buf.sv | 26 ++
 rtl/fft_frame_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fft_sched_pkg.sv
// fft_sched_pkg: shared state encoding and sizing helpers for the FFT frame scheduler.
package fft_sched_pkg;
  typedef enum logic [1:0] {FILL, ISSUE, GAP} state_e;
  localparam int NUM_SAMPLES_DEF = 64;
  localparam int QUADS = NUM_SAMPLES_DEF / 4;
  localparam int QAW = $clog2(QUADS);
  function automatic int quads(input int n);
    return n / 4;
  endfunction
  function automatic int quad_aw(input int n);
    return $clog2(n / 4);
  endfunction
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: quad-wide frame buffer with per-lane write enables and a registered read port.
module fft_frame_buf
  import fft_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = QUADS,
  parameter int AW = QAW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [8*WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [8*WIDTH-1:0] rdata_o
);
  logic [8*WIDTH-1:0] mem_q [DEPTH];
  // each lane is one packed {imag, real} pair
  always_ff @(posedge clock)
    for (int l = 0; l < 4; l++)
      if (we_i[l]) mem_q[waddr_i][l*2*WIDTH +: 2*WIDTH] <= wdata_i[l*2*WIDTH +: 2*WIDTH];
  always_ff @(posedge clock or posedge reset)
    if (reset) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: packs a serial sample stream into frames, bursts them into the SDF chain
// with a flush gap, and tracks in-flight frames from the last stage's output beats.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_SAMPLES = 64,
  parameter int FLUSH_GAP = 24,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [WIDTH-1:0]                  s_real_i,
  input  logic [WIDTH-1:0]                  s_imag_i,
  input  logic                              s_last_i,
  output logic                              m_input_en_o,
  output logic [WIDTH-1:0]                  m_real_0_o,
  output logic [WIDTH-1:0]                  m_real_1_o,
  output logic [WIDTH-1:0]                  m_real_2_o,
  output logic [WIDTH-1:0]                  m_real_3_o,
  output logic [WIDTH-1:0]                  m_imag_0_o,
  output logic [WIDTH-1:0]                  m_imag_1_o,
  output logic [WIDTH-1:0]                  m_imag_2_o,
  output logic [WIDTH-1:0]                  m_imag_3_o,
  input  logic                              p_output_en_i,
  output logic                              frame_done_o,
  output logic                              frame_err_o,
  output logic                              busy_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o
);
  localparam int Q = quads(NUM_SAMPLES);
  localparam int AW = quad_aw(NUM_SAMPLES);
  localparam int CW = $clog2(NUM_SAMPLES) + 1;
  localparam int GW = $clog2(FLUSH_GAP + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_SAMPLES);
  localparam logic [GW-1:0] ISS_LAST = GW'(Q - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(FLUSH_GAP - 1);
  localparam logic [AW-1:0] BEAT_LAST = AW'(Q - 1);
  localparam logic [IW-1:0] IF_MAX = IW'(MAX_INFLIGHT);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gc_q, gc_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [IW-1:0] infl_q, infl_d;
  logic en_q, done_q, done_d, err_q, err_d;
  logic ready, accept, last_smp, early_last, issue_start, stray, beat_wrap;
  logic [8*WIDTH-1:0] rdata;

  assign ready       = state_q != ISSUE && cnt_q != CNT_FULL && infl_q < IF_MAX;
  assign s_ready_o   = ready & ~reset;
  assign accept      = s_valid_i & ready;
  assign last_smp    = accept && cnt_q == CNT_LAST;
  assign early_last  = accept && s_last_i && !last_smp;
  assign issue_start = state_q == ISSUE && gc_q == '0;
  assign stray       = p_output_en_i && infl_q == '0 && beat_q == '0;
  assign beat_wrap   = p_output_en_i && !stray && beat_q == BEAT_LAST;

  // gc_q counts burst beats in ISSUE and idle cycles in GAP
  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    cnt_d   = early_last ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    if (state_q == FILL && last_smp) begin
      state_d = ISSUE;
      cnt_d   = '0;
    end else if (state_q == ISSUE) begin
      state_d = gc_q == ISS_LAST ? GAP : ISSUE;
      gc_d    = gc_q == ISS_LAST ? '0 : gc_q + GW'(1);
    end else if (state_q == GAP && gc_q == GAP_LAST) begin
      state_d = cnt_d == CNT_FULL ? ISSUE : FILL;
      cnt_d   = cnt_d == CNT_FULL ? '0 : cnt_d;
      gc_d    = '0;
    end else if (state_q == GAP) begin
      gc_d = gc_q + GW'(1);
    end
    beat_d = stray || !p_output_en_i ? beat_q : beat_wrap ? '0 : beat_q + AW'(1);
    infl_d = infl_q + IW'(issue_start) - IW'(beat_wrap);
    done_d = beat_wrap;
    err_d  = early_last | (last_smp & ~s_last_i) | stray;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      gc_q    <= '0;
      beat_q  <= '0;
      infl_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gc_q    <= gc_d;
      beat_q  <= beat_d;
      infl_q  <= infl_d;
      en_q    <= state_q == ISSUE;
      done_q  <= done_d;
      err_q   <= err_d;
    end

  fft_frame_buf #(.WIDTH(WIDTH), .DEPTH(Q), .AW(AW)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .we_i    (accept ? 4'b1 << cnt_q[1:0] : 4'b0),
    .waddr_i (cnt_q[AW+1:2]),
    .wdata_i ({4{s_imag_i, s_real_i}}),
    .re_i    (state_q == ISSUE),
    .raddr_i (gc_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign m_input_en_o = en_q;
  assign m_real_0_o   = rdata[0*2*WIDTH +: WIDTH];
  assign m_imag_0_o   = rdata[0*2*WIDTH+WIDTH +: WIDTH];
  assign m_real_1_o   = rdata[1*2*WIDTH +: WIDTH];
  assign m_imag_1_o   = rdata[1*2*WIDTH+WIDTH +: WIDTH];
  assign m_real_2_o   = rdata[2*2*WIDTH +: WIDTH];
  assign m_imag_2_o   = rdata[2*2*WIDTH+WIDTH +: WIDTH];
  assign m_real_3_o   = rdata[3*2*WIDTH +: WIDTH];
  assign m_imag_3_o   = rdata[3*2*WIDTH+WIDTH +: WIDTH];
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign busy_o       = state_q != FILL || cnt_q != '0 || infl_q != '0;
  assign inflight_o   = infl_q;
endmodule
